// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the multi-channel clock divider.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
// Optional feature macro used by this block: CLKDIV_CTRL_READBACK_EN.
package clkdiv_pkg;

    // Default divisor width. A build that overrides Width uses the module-local
    // equivalents of div_t and cfg_t.
    localparam int DivWidth = 16;

    // 50 MHz core clock divided down to 9600 Hz.
    localparam int ResetDivDefault = 5208;

    typedef logic [DivWidth-1:0] div_t;

    typedef struct packed {
        div_t div;
        logic ena;
    } cfg_t;

    // Channel index width. Keeps at least one bit so a single-channel build
    // still has a legal select port.
    function automatic int chan_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: counter, shadow register and boundary-aligned activation.
// Latency: tick/ckout/pending are combinational from state; a staged write is visible one cycle after acceptance.
// Backpressure: pending_o high means the shadow is occupied; the parent must not assert wr_i then.
// Ports: clk_i/rst_i (async active-high), wr_i + wr_div_i/wr_ena_i stage a config,
//        tick_o/ckout_o/pending_o status; div_o/cnt_o/ena_o only with CLKDIV_CTRL_READBACK_EN.
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int Width    = 16,
    parameter int ResetDiv = ResetDivDefault
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_i,
    input  logic [Width-1:0] wr_div_i,
    input  logic             wr_ena_i,
    output logic             tick_o,
    output logic             ckout_o,
    output logic             pending_o
`ifdef CLKDIV_CTRL_READBACK_EN
    ,
    output logic [Width-1:0] div_o,
    output logic [Width-1:0] cnt_o,
    output logic             ena_o
`endif
);

    typedef struct packed {
        logic [Width-1:0] div;
        logic             ena;
    } shadow_t;

    localparam logic [Width-1:0] One       = Width'(1);
    localparam logic [Width-1:0] ResetDivW = (ResetDiv < 1) ? One : Width'(ResetDiv);

    logic [Width-1:0] div_q, div_d;
    logic [Width-1:0] cnt_q, cnt_d;
    logic             ena_q, ena_d;
    shadow_t          sh_q, sh_d;
    logic             pend_q, pend_d;

    logic at_end;
    logic tick_raw;
    logic act;

    assign at_end   = (cnt_q == div_q - One);
    assign tick_raw = ena_q & at_end;
    // Swap in the shadow at the period boundary, or straight away when idle.
    assign act      = pend_q & (tick_raw | ~ena_q);

    assign tick_o    = ~rst_i & tick_raw;
    // D=1 has no low/high split; the wave stays low.
    assign ckout_o   = ~rst_i & ena_q & (div_q != One) & (cnt_q >= (div_q >> 1));
    // Cleared in the activation cycle so the parent can accept the next write
    // on the same edge that retires the current one.
    assign pending_o = pend_q & ~act;

    always_comb begin
        div_d  = div_q;
        ena_d  = ena_q;
        cnt_d  = cnt_q;
        sh_d   = sh_q;
        pend_d = pend_q;

        if (act) begin
            div_d  = sh_q.div;
            ena_d  = sh_q.ena;
            cnt_d  = '0;
            pend_d = 1'b0;
        end else if (ena_q) begin
            cnt_d = at_end ? '0 : cnt_q + One;
        end else begin
            cnt_d = '0;
        end

        // A write on the activation edge restages; the retiring value has
        // already been copied into div_d/ena_d above.
        if (wr_i) begin
            sh_d.div = (wr_div_i == '0) ? One : wr_div_i;
            sh_d.ena = wr_ena_i;
            pend_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q  <= ResetDivW;
            ena_q  <= 1'b1;
            cnt_q  <= '0;
            sh_q   <= '0;
            pend_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            ena_q  <= ena_d;
            cnt_q  <= cnt_d;
            sh_q   <= sh_d;
            pend_q <= pend_d;
        end
    end

`ifdef CLKDIV_CTRL_READBACK_EN
    assign div_o = div_q;
    assign cnt_o = cnt_q;
    assign ena_o = ena_q;
`endif

endmodule

// File: rtl/clkdiv_ctrl.sv
// Multi-channel clock divider: config write decode and ready muxing over clkdiv_chan instances.
// Latency: write staged one cycle after acceptance; active at the channel's next period boundary.
// Backpressure: cfg_ready = ~pending of the addressed channel; out-of-range channels always accept and drop.
// Ports: clock/reset (async active-high); cfg_valid/cfg_ready/cfg_chan/cfg_div/cfg_ena write port;
//        tick/ckout/pending per channel. CLKDIV_CTRL_READBACK_EN adds rd_chan -> rd_div/rd_cnt/rd_ena (1-cycle).
module clkdiv_ctrl
    import clkdiv_pkg::*;
#(
    parameter int Channels = 4,
    parameter int Width    = 16,
    parameter int ResetDiv = ResetDivDefault
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   cfg_valid,
    output logic                                   cfg_ready,
    input  logic [chan_idx_width(Channels)-1:0]    cfg_chan,
    input  logic [Width-1:0]                       cfg_div,
    input  logic                                   cfg_ena,
    output logic [Channels-1:0]                    tick,
    output logic [Channels-1:0]                    ckout,
    output logic [Channels-1:0]                    pending
`ifdef CLKDIV_CTRL_READBACK_EN
    ,
    input  logic [chan_idx_width(Channels)-1:0]    rd_chan,
    output logic [Width-1:0]                       rd_div,
    output logic [Width-1:0]                       rd_cnt,
    output logic                                   rd_ena
`endif
);

    logic [31:0]         cfg_chan_ext;
    logic [Channels-1:0] wr_sel;

    // Widened so indices past Channels (non power-of-two builds) never match.
    assign cfg_chan_ext = 32'(cfg_chan);

    always_comb begin
        cfg_ready = 1'b1;
        wr_sel    = '0;
        for (int i = 0; i < Channels; i++) begin
            if (cfg_chan_ext == 32'(i)) begin
                cfg_ready = ~pending[i];
                wr_sel[i] = cfg_valid & ~pending[i];
            end
        end
    end

`ifdef CLKDIV_CTRL_READBACK_EN
    logic [Width-1:0]    ch_div [Channels];
    logic [Width-1:0]    ch_cnt [Channels];
    logic [Channels-1:0] ch_ena;
`endif

    for (genvar g = 0; g < Channels; g++) begin : g_chan
        clkdiv_chan #(
            .Width    (Width),
            .ResetDiv (ResetDiv)
        ) u_chan (
            .clk_i     (clock),
            .rst_i     (reset),
            .wr_i      (wr_sel[g]),
            .wr_div_i  (cfg_div),
            .wr_ena_i  (cfg_ena),
            .tick_o    (tick[g]),
            .ckout_o   (ckout[g]),
            .pending_o (pending[g])
`ifdef CLKDIV_CTRL_READBACK_EN
            ,
            .div_o     (ch_div[g]),
            .cnt_o     (ch_cnt[g]),
            .ena_o     (ch_ena[g])
`endif
        );
    end

`ifdef CLKDIV_CTRL_READBACK_EN
    logic [31:0]      rd_chan_ext;
    logic [Width-1:0] rd_div_q, rd_div_d;
    logic [Width-1:0] rd_cnt_q, rd_cnt_d;
    logic             rd_ena_q, rd_ena_d;

    assign rd_chan_ext = 32'(rd_chan);

    always_comb begin
        rd_div_d = '0;
        rd_cnt_d = '0;
        rd_ena_d = 1'b0;
        for (int i = 0; i < Channels; i++) begin
            if (rd_chan_ext == 32'(i)) begin
                rd_div_d = ch_div[i];
                rd_cnt_d = ch_cnt[i];
                rd_ena_d = ch_ena[i];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_div_q <= '0;
            rd_cnt_q <= '0;
            rd_ena_q <= 1'b0;
        end else begin
            rd_div_q <= rd_div_d;
            rd_cnt_q <= rd_cnt_d;
            rd_ena_q <= rd_ena_d;
        end
    end

    assign rd_div = rd_div_q;
    assign rd_cnt = rd_cnt_q;
    assign rd_ena = rd_ena_q;
`endif

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Directed self-checking bench for clkdiv_ctrl (3 channels, reset divisor 4).
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled there or 1 unit later.
// Backpressure: writes wait on cfg_ready with a bounded cycle budget.
module tb_clkdiv_ctrl;

    localparam int NCh  = 3;
    localparam int W    = 16;
    localparam int RDiv = 4;

    logic           clock = 1'b0;
    logic           reset;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [1:0]     cfg_chan;
    logic [W-1:0]   cfg_div;
    logic           cfg_ena;
    logic [NCh-1:0] tick;
    logic [NCh-1:0] ckout;
    logic [NCh-1:0] pending;

    int checks = 0;
    int errors = 0;

    clkdiv_ctrl #(
        .Channels (NCh),
        .Width    (W),
        .ResetDiv (RDiv)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_div   (cfg_div),
        .cfg_ena   (cfg_ena),
        .tick      (tick),
        .ckout     (ckout),
        .pending   (pending)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input logic [1:0] ch, input logic [W-1:0] dv, input logic en);
        int n = 0;
        cfg_chan  = ch;
        cfg_div   = dv;
        cfg_ena   = en;
        cfg_valid = 1'b1;
        #1;
        while (cfg_ready !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("wr_accept", {31'd0, cfg_ready}, 32'd1);
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_pend_clear(input logic [NCh-1:0] mask, input string tag);
        int n = 0;
        while ((pending & mask) != '0 && n < 40) begin
            step();
            n++;
        end
        chk(tag, 32'(pending & mask), 32'd0);
    endtask

    // Every channel at D=4 from C=0: tick on the 4th cycle, ckout 0,0,1,1.
    task automatic chk_reset_pattern(input string tag);
        for (int k = 0; k < 8; k++) begin
            chk({tag, "_tick"},  32'(tick),  (k % 4 == 3) ? 32'h7 : 32'h0);
            chk({tag, "_ckout"}, 32'(ckout), (k % 4 >= 2) ? 32'h7 : 32'h0);
            step();
        end
    endtask

    initial begin
        reset     = 1'b1;
        cfg_valid = 1'b0;
        cfg_chan  = '0;
        cfg_div   = '0;
        cfg_ena   = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_tick",    32'(tick),    32'd0);
        chk("rst_ckout",   32'(ckout),   32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", {31'd0, cfg_ready}, 32'd1);
        chk_reset_pattern("rstdiv");

        // Disable ch0, then bring it up at D=10 from a known C=0.
        do_write(2'd0, 16'd10, 1'b0);
        wait_pend_clear(3'b001, "dis0_act");
        step();
        chk("dis0_tick",  {31'd0, tick[0]},  32'd0);
        chk("dis0_ckout", {31'd0, ckout[0]}, 32'd0);
        step();
        chk("dis0_tick2", {31'd0, tick[0]},  32'd0);
        do_write(2'd0, 16'd10, 1'b1);
        step();
        for (int k = 0; k < 3; k++) begin
            chk("d10_tick", {31'd0, tick[0]}, 32'd0);
            step();
        end
        // At C=3 of D=10: stage div=4; old period must still run to C=9.
        do_write(2'd0, 16'd4, 1'b1);
        chk("d10_pend_set", {31'd0, pending[0]}, 32'd1);
        chk("d10_ck_c4",    {31'd0, ckout[0]},   32'd0);
        step();
        chk("d10_ck_c5",    {31'd0, ckout[0]},   32'd1);
        for (int k = 5; k < 9; k++) begin
            chk("d10_tick_mid", {31'd0, tick[0]},    32'd0);
            chk("d10_pend_mid", {31'd0, pending[0]}, 32'd1);
            step();
        end
        chk("d10_tick_c9", {31'd0, tick[0]},    32'd1);
        chk("d10_pend_c9", {31'd0, pending[0]}, 32'd0);
        step();
        for (int k = 0; k < 8; k++) begin
            chk("d4_tick",  {31'd0, tick[0]},  (k % 4 == 3) ? 32'd1 : 32'd0);
            chk("d4_ckout", {31'd0, ckout[0]}, (k % 4 >= 2) ? 32'd1 : 32'd0);
            chk("d4_pend",  {31'd0, pending[0]}, 32'd0);
            step();
        end

        // Ch0 is at C=0 of D=4: stage 6, then try 3 while pending.
        cfg_chan  = 2'd0;
        cfg_div   = 16'd6;
        cfg_ena   = 1'b1;
        cfg_valid = 1'b1;
        #1;
        chk("a_ready", {31'd0, cfg_ready}, 32'd1);
        step();
        cfg_div = 16'd3;
        #1;
        chk("b_stall1", {31'd0, cfg_ready},  32'd0);
        chk("b_pend",   {31'd0, pending[0]}, 32'd1);
        step();
        chk("b_stall2", {31'd0, cfg_ready},  32'd0);
        step();
        chk("act_tick",  {31'd0, tick[0]},    32'd1);
        chk("act_ready", {31'd0, cfg_ready},  32'd1);
        chk("act_pend",  {31'd0, pending[0]}, 32'd0);
        step();
        cfg_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("d6_tick",  {31'd0, tick[0]},    (k == 5) ? 32'd1 : 32'd0);
            chk("d6_ckout", {31'd0, ckout[0]},   (k >= 3) ? 32'd1 : 32'd0);
            chk("d6_pend",  {31'd0, pending[0]}, (k != 5) ? 32'd1 : 32'd0);
            step();
        end
        for (int k = 0; k < 3; k++) begin
            chk("d3_tick",  {31'd0, tick[0]},  (k == 2) ? 32'd1 : 32'd0);
            chk("d3_ckout", {31'd0, ckout[0]}, (k >= 1) ? 32'd1 : 32'd0);
            step();
        end

        // Ch1: disable, then enable at D=7 from the disabled state.
        do_write(2'd1, 16'd9, 1'b0);
        wait_pend_clear(3'b010, "dis1_act");
        step();
        for (int k = 0; k < 3; k++) begin
            chk("dis1_tick",  {31'd0, tick[1]},  32'd0);
            chk("dis1_ckout", {31'd0, ckout[1]}, 32'd0);
            step();
        end
        do_write(2'd1, 16'd7, 1'b1);
        step();
        for (int k = 0; k < 7; k++) begin
            chk("d7_tick",  {31'd0, tick[1]},  (k == 6) ? 32'd1 : 32'd0);
            chk("d7_ckout", {31'd0, ckout[1]}, (k >= 3) ? 32'd1 : 32'd0);
            step();
        end

        // Ch2: div=0 is stored as 1, then an explicit div=1.
        do_write(2'd2, 16'd0, 1'b1);
        wait_pend_clear(3'b100, "div0_act");
        step();
        for (int k = 0; k < 4; k++) begin
            chk("div0_tick",  {31'd0, tick[2]},  32'd1);
            chk("div0_ckout", {31'd0, ckout[2]}, 32'd0);
            step();
        end
        do_write(2'd2, 16'd1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk("div1_tick",  {31'd0, tick[2]},  32'd1);
            chk("div1_ckout", {31'd0, ckout[2]}, 32'd0);
            step();
        end

        // Out-of-range channel: accepted, nothing staged.
        cfg_chan  = 2'd3;
        cfg_div   = 16'd2;
        cfg_ena   = 1'b0;
        cfg_valid = 1'b1;
        #1;
        chk("oor_ready", {31'd0, cfg_ready}, 32'd1);
        step();
        cfg_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("oor_pending", 32'(pending), 32'd0);
            chk("oor_tick2",   {31'd0, tick[2]}, 32'd1);
            step();
        end

        // Long periods everywhere, then stage on all three and reset.
        do_write(2'd0, 16'd20, 1'b1);
        do_write(2'd1, 16'd20, 1'b1);
        do_write(2'd2, 16'd20, 1'b1);
        wait_pend_clear(3'b111, "long_act");
        do_write(2'd0, 16'd9, 1'b1);
        do_write(2'd1, 16'd9, 1'b1);
        do_write(2'd2, 16'd9, 1'b1);
        chk("all_pending", 32'(pending), 32'h7);
        reset = 1'b1;
        #1;
        chk("rst2_pending", 32'(pending), 32'd0);
        chk("rst2_tick",    32'(tick),    32'd0);
        chk("rst2_ckout",   32'(ckout),   32'd0);
        step();
        step();
        reset = 1'b0;
        #1;
        chk("ready_after_rst2", {31'd0, cfg_ready}, 32'd1);
        chk_reset_pattern("rst2div");
        chk("rst2_pending_end", 32'(pending), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clkdiv_ctrl.md
CLKDIV_CTRL -- requirements
Module: clkdiv_ctrl

Interface
REQ-001 SHALL have parameter Channels, default 4: number of independent divider channels (1..8).
REQ-002 SHALL have parameter Width, default 16: divisor and counter width in bits.
REQ-003 SHALL have parameter ResetDiv, default 5208: divisor loaded into every channel at reset (50 MHz to 9600 Hz).
REQ-004 SHALL have port clock, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port cfg_valid, input, 1: configuration write request.
REQ-007 SHALL have port cfg_ready, output, 1: write accepted when cfg_valid and cfg_ready are both high in the same cycle.
REQ-008 SHALL have port cfg_chan, input, $clog2(Channels) (minimum 1): target channel index.
REQ-009 SHALL have port cfg_div, input, Width: new divisor.
REQ-010 SHALL have port cfg_ena, input, 1: new channel enable.
REQ-011 SHALL have port tick, output, Channels: one-cycle strobe per channel period.
REQ-012 SHALL have port ckout, output, Channels: divided square wave per channel.
REQ-013 SHALL have port pending, output, Channels: a staged configuration is waiting for its channel boundary.

Function
REQ-014 Each channel SHALL hold an active divisor D, an enable E and a counter C; while E=1, C SHALL count 0..D-1 and wrap to 0.
REQ-015 tick[i] SHALL be high in exactly the cycle where E=1 and C=D-1; period SHALL be D cycles.
REQ-016 ckout[i] SHALL be low for C < floor(D/2) and high otherwise; for odd D the high phase SHALL be one cycle longer.
REQ-017 D=1 SHALL give tick high every enabled cycle with ckout held low; cfg_div=0 SHALL be stored as 1.
REQ-018 While E=0, C SHALL hold 0 and tick and ckout SHALL be 0.
REQ-019 An accepted write SHALL stage {cfg_div, cfg_ena} into the channel's shadow register and set pending[cfg_chan] in the next cycle.
REQ-020 A staged configuration SHALL become active in the tick cycle of its channel: the next cycle starts C=0 with the new D and E; no truncated or stretched period SHALL occur.
REQ-021 If the channel is disabled (E=0), a staged configuration SHALL become active in the cycle after acceptance, with C=0.
REQ-022 cfg_ready SHALL equal ~pending[cfg_chan] (combinational); a write to a channel with pending set SHALL stall.
REQ-023 A write accepted in the same cycle a channel's staged configuration activates SHALL be staged as a new pending configuration; the activating value SHALL NOT be lost.
REQ-024 cfg_chan >= Channels SHALL be accepted and discarded with no state change.
REQ-025 Channels SHALL be fully independent; simultaneous ticks and activations on any subset SHALL be supported.

Reset
REQ-026 On reset every channel SHALL take D=ResetDiv, E=1, C=0 with the shadow register cleared and pending=0.
REQ-027 During reset tick=0 and ckout=0; cfg_ready SHALL be 1 from the first cycle after reset release.
REQ-028 Reset asserted mid-period or with pending set SHALL discard all staged configurations.

Configuration
REQ-029 Macro CLKDIV_CTRL_READBACK_EN defined SHALL add input rd_chan ($clog2(Channels)) and outputs rd_div (Width), rd_cnt (Width) and rd_ena (1), registered with one-cycle latency, reporting the active D, C and E of rd_chan.
REQ-030 Without CLKDIV_CTRL_READBACK_EN these ports and their registers SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-031 Package clkdiv_pkg SHALL hold the div_t typedef (Width-bit divisor), the cfg_t struct {div, ena} and the ResetDiv default constant.
REQ-032 Per-channel counter, shadow register and activation logic SHALL live in sub-module clkdiv_chan, instantiated Channels times by generate; clkdiv_ctrl SHALL hold only write decode and ready muxing.

Verification
REQ-033 Reset release, no writes, ResetDiv=4 -> tick on each channel every 4 cycles; ckout pattern 0,0,1,1.
REQ-034 Channel 0 at D=10: write div=4 at C=3 -> pending=1, old period completes at C=9, then 4-cycle periods begin; pending clears when the new value activates.
REQ-035 Second write to channel 0 while pending -> cfg_ready=0 and write stalls until the activation cycle; the second value takes effect at the following boundary.
REQ-036 Write ena=0 then div=7, ena=1 on a disabled channel -> first tick 7 cycles after activation; ckout low 3 cycles, high 4.
REQ-037 cfg_div=0 and cfg_div=1 -> tick every cycle, ckout constantly 0; cfg_chan=Channels -> no channel changes.
REQ-038 Reset asserted with pending set on all channels -> pending=0 and D=ResetDiv on release.
